// File: rtl/riscv_mmio_bridge_if.sv
// CPU/cache data-port bundle seen by the MMIO bridge.
interface riscv_mmio_bridge_if #(
  parameter int CACHE_D_WRITE_LEN = 2
) ();
  logic [31:0]                  addr;
  logic                         cache_d_write_en;
  logic [CACHE_D_WRITE_LEN-1:0] cache_d_write;
  logic [31:0]                  data_to_cache;
  logic [31:0]                  mem_data_in;
  logic                         mem_write_en;
  logic                         io_sel;
  logic [31:0]                  data_out;

  modport master (
    output addr, cache_d_write_en, cache_d_write, data_to_cache, mem_data_in,
    input  mem_write_en, io_sel, data_out
  );

  modport slave (
    input  addr, cache_d_write_en, cache_d_write, data_to_cache, mem_data_in,
    output mem_write_en, io_sel, data_out
  );
endinterface

// File: rtl/riscv_mmio_bridge.sv
// MMIO bridge: 256-byte I/O window with debounced switches, LED register and
// a compare-match cycle timer; stores into the window never reach the cache.
module riscv_mmio_bridge #(
  parameter logic [31:0] IO_BASE           = 32'hFFFFFC00,
  parameter int          SW_WIDTH          = 24,
  parameter int          LED_WIDTH         = 24,
  parameter int          DEBOUNCE_CYCLES   = 100000,
  parameter int          CACHE_D_WRITE_LEN = 2,
  parameter logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SB = 'd0,
  parameter logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SH = 'd1,
  parameter logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SW = 'd2
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_mmio_bridge_if.slave   bus,
  input  logic [SW_WIDTH-1:0]  sw,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq
);

  localparam logic [5:0]  OFF_SW = 6'd0, OFF_LED = 6'd1, OFF_EDGE = 6'd2,
                          OFF_TIMER = 6'd3, OFF_CMP = 6'd4, OFF_STATUS = 6'd5,
                          OFF_CTRL = 6'd6;
  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sync1_q, sw_sync_q, sw_db_q, sw_db_d, edge_q, edge_d, edge_set;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          cnt_q, cnt_d, timer_q, timer_d, cmp_q, cmp_d;
  logic                 status_q, status_d, ctrl_q, ctrl_d;

  logic [3:0]  be;
  logic [31:0] wdata, mask, clr, led_m, timer_m, cmp_m, rdata;
  logic [5:0]  off;
  logic        wr;

  assign off              = bus.addr[7:2];
  assign bus.io_sel       = (bus.addr[31:8] == IO_BASE[31:8]);
  assign bus.mem_write_en = bus.cache_d_write_en & ~bus.io_sel;
  assign bus.data_out     = bus.io_sel ? rdata : bus.mem_data_in;
  assign led              = led_q;
  assign irq              = status_q & ctrl_q;

  // Lane decode: a misaligned halfword yields an empty mask, dropping the write.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.data_to_cache;
    case (bus.cache_d_write)
      CACHE_D_WRITE_SW: be = 4'b1111;
      CACHE_D_WRITE_SH: begin
        be    = bus.addr[0] ? 4'b0000 : (bus.addr[1] ? 4'b1100 : 4'b0011);
        wdata = {2{bus.data_to_cache[15:0]}};
      end
      CACHE_D_WRITE_SB: begin
        be    = 4'b0001 << bus.addr[1:0];
        wdata = {4{bus.data_to_cache[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    clr  = wdata & mask;
  end

  assign wr      = bus.cache_d_write_en & bus.io_sel & (|be);
  assign led_m   = (32'(led_q) & ~mask) | clr;
  assign timer_m = (timer_q & ~mask) | clr;
  assign cmp_m   = (cmp_q & ~mask) | clr;

  always_comb begin
    sw_db_d  = sw_db_q;
    cnt_d    = '0;
    edge_set = '0;
    if (sw_sync_q != sw_db_q) begin
      if (cnt_q == DB_LAST) begin
        sw_db_d  = sw_sync_q;
        edge_set = sw_db_q ^ sw_sync_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    led_d    = (wr && off == OFF_LED) ? led_m[LED_WIDTH-1:0] : led_q;
    edge_d   = edge_q;
    if (wr && off == OFF_EDGE) edge_d = edge_q & ~clr[SW_WIDTH-1:0];
    edge_d   = edge_d | edge_set;
    timer_d  = (wr && off == OFF_TIMER) ? timer_m : timer_q + 32'd1;
    cmp_d    = (wr && off == OFF_CMP) ? cmp_m : cmp_q;
    // Compare uses the pre-write timer, and a hardware set wins over W1C.
    status_d = ((wr && off == OFF_STATUS) ? status_q & ~clr[0] : status_q)
               | (timer_q == cmp_q);
    ctrl_d   = (wr && off == OFF_CTRL && be[0]) ? wdata[0] : ctrl_q;
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_SW:     rdata = 32'(sw_db_q);
      OFF_LED:    rdata = 32'(led_q);
      OFF_EDGE:   rdata = 32'(edge_q);
      OFF_TIMER:  rdata = timer_q;
      OFF_CMP:    rdata = cmp_q;
      OFF_STATUS: rdata = {31'd0, status_q};
      OFF_CTRL:   rdata = {31'd0, ctrl_q};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sw_sync_q <= '0;
      sw_db_q   <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      cmp_q     <= 32'hFFFFFFFF;
      status_q  <= 1'b0;
      ctrl_q    <= 1'b0;
    end else begin
      sync1_q   <= sw;
      sw_sync_q <= sync1_q;
      sw_db_q   <= sw_db_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      status_q  <= status_d;
      ctrl_q    <= ctrl_d;
    end
  end

endmodule

// File: tb/tb_riscv_mmio_bridge.sv
// Directed bench for riscv_mmio_bridge with a short debounce window.
module tb_riscv_mmio_bridge;
  localparam logic [31:0] B  = 32'hFFFFFC00;
  localparam logic [1:0]  SB = 2'd0, SH = 2'd1, SW = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sw, led;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  riscv_mmio_bridge_if #(.CACHE_D_WRITE_LEN(2)) bus ();

  riscv_mmio_bridge #(
    .IO_BASE(B), .SW_WIDTH(24), .LED_WIDTH(24), .DEBOUNCE_CYCLES(4),
    .CACHE_D_WRITE_LEN(2), .CACHE_D_WRITE_SB(SB), .CACHE_D_WRITE_SH(SH),
    .CACHE_D_WRITE_SW(SW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .sw(sw), .led(led), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bus.addr             = a;
    bus.cache_d_write_en = 1'b0;
    #1;
    chk(tag, bus.data_out, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    bus.addr             = a;
    bus.cache_d_write    = sz;
    bus.data_to_cache    = d;
    bus.cache_d_write_en = 1'b1;
    #1;
    chk("io_store_mwe", {31'd0, bus.mem_write_en}, 32'd0);
    tick();
    bus.cache_d_write_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = '0;
    bus.addr = '0; bus.cache_d_write_en = 1'b0; bus.cache_d_write = SW;
    bus.data_to_cache = '0; bus.mem_data_in = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    chk("rst_led", {8'd0, led}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(B + 32'h00, "rst_sw", 32'd0);
    rd(B + 32'h0C, "rst_timer", 32'd0);
    tick();
    rd(B + 32'h10, "rst_cmp", 32'hFFFFFFFF);
    rd(B + 32'h14, "rst_status", 32'd0);
    rd(B + 32'h18, "rst_ctrl", 32'd0);
    rd(B + 32'h08, "rst_edge", 32'd0);
    tick();

    // LED lane merging
    wr(B + 32'h4, SW, 32'h11223344);
    rd(B + 32'h4, "led_sw", 32'h00223344);
    wr(B + 32'h5, SB, 32'h000000AA);
    wr(B + 32'h6, SH, 32'h0000BEEF);
    rd(B + 32'h4, "led_merged", 32'h00EFAA44);
    rd(B + 32'h7, "led_low_bits_ignored", 32'h00EFAA44);
    chk("led_port", {8'd0, led}, 32'h00EFAA44);

    // debounce latency: k+1+4 edges
    sw = 24'h000005;
    repeat (5) tick();
    rd(B + 32'h0, "db_not_yet", 32'd0);
    tick();
    rd(B + 32'h0, "db_sw", 32'd5);
    rd(B + 32'h8, "db_edge", 32'd5);

    // 3-cycle glitch is filtered
    sw = 24'h000002;
    repeat (3) tick();
    sw = 24'h000005;
    repeat (8) tick();
    rd(B + 32'h0, "glitch_sw", 32'd5);
    rd(B + 32'h8, "glitch_edge", 32'd5);

    // W1C by byte, then hardware set beating a clear
    wr(B + 32'h8, SB, 32'h00000001);
    rd(B + 32'h8, "w1c_bit0", 32'd4);
    sw = 24'h000001;
    repeat (5) tick();
    wr(B + 32'h8, SB, 32'h00000004);
    rd(B + 32'h8, "set_beats_clr", 32'd4);
    rd(B + 32'h0, "sw_fall", 32'd1);
    wr(B + 32'h8, SW, 32'hFFFFFFFF);
    rd(B + 32'h8, "w1c_all", 32'd0);

    // timer compare and irq
    wr(B + 32'h18, SW, 32'd1);
    wr(B + 32'h10, SW, 32'd20);
    wr(B + 32'h0C, SW, 32'd10);
    rd(B + 32'h0C, "timer_load", 32'd10);
    repeat (10) tick();
    rd(B + 32'h14, "status_before", 32'd0);
    chk("irq_before", {31'd0, irq}, 32'd0);
    tick();
    rd(B + 32'h14, "status_match", 32'd1);
    chk("irq_match", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_held", {31'd0, irq}, 32'd1);
    wr(B + 32'h14, SB, 32'h00000001);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd(B + 32'h14, "status_cleared", 32'd0);

    // wrap
    wr(B + 32'h0C, SW, 32'hFFFFFFFE);
    rd(B + 32'h0C, "wrap_fe", 32'hFFFFFFFE);
    tick(); rd(B + 32'h0C, "wrap_ff", 32'hFFFFFFFF);
    tick(); rd(B + 32'h0C, "wrap_0", 32'd0);
    tick(); rd(B + 32'h0C, "wrap_1", 32'd1);

    // dropped misaligned halfword, unmapped offset
    wr(B + 32'h5, SH, 32'h00001234);
    rd(B + 32'h4, "sh_misaligned", 32'h00EFAA44);
    wr(B + 32'h40, SW, 32'hDEADBEEF);
    rd(B + 32'h40, "unmapped_rd", 32'd0);
    chk("unmapped_iosel", {31'd0, bus.io_sel}, 32'd1);
    bus.addr = B + 32'hFF; #1;
    chk("window_top_iosel", {31'd0, bus.io_sel}, 32'd1);
    bus.addr = B + 32'h100; #1;
    chk("window_end_iosel", {31'd0, bus.io_sel}, 32'd0);

    // outside the window
    tick();
    bus.addr = 32'h00001000; bus.mem_data_in = 32'hCAFEBABE; #1;
    chk("mem_data_out", bus.data_out, 32'hCAFEBABE);
    chk("mem_iosel", {31'd0, bus.io_sel}, 32'd0);
    bus.cache_d_write = SW; bus.cache_d_write_en = 1'b1; #1;
    chk("mem_store_mwe", {31'd0, bus.mem_write_en}, 32'd1);
    tick();
    bus.cache_d_write_en = 1'b0;

    // reset mid-debounce, then a fresh switch change
    sw = 24'h000000;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(B + 32'h0, "rst2_sw", 32'd0);
    rd(B + 32'h10, "rst2_cmp", 32'hFFFFFFFF);
    rd(B + 32'h8, "rst2_edge", 32'd0);
    tick();
    rd(B + 32'h14, "rst2_status", 32'd0);
    chk("rst2_led", {8'd0, led}, 32'd0);
    sw = 24'h000003;
    repeat (6) tick();
    rd(B + 32'h0, "post_rst_sw", 32'd3);
    rd(B + 32'h8, "post_rst_edge", 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
